// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: valid/ready pipeline register with a 2-entry skid buffer.
// Optional saturating stall/bubble counters are enabled by defining PIPE_PERF_CNT_EN.
module elastic_pipe_stage #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 168,
  parameter int PERF_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t state;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic in_acc;
  assign in_acc = in_valid & in_ready;
  // Control bits are zeroed whenever an entry leaves, so an empty stage never asserts side effects.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_ctrl  <= '0;
      out_data  <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_ctrl  <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: if (in_acc) begin
          state     <= BUSY;
          out_valid <= 1'b1;
          out_ctrl  <= in_ctrl;
          out_data  <= in_data;
        end
        BUSY: if (in_acc && out_ready) begin
          out_ctrl <= in_ctrl;
          out_data <= in_data;
        end else if (in_acc) begin
          state     <= FULL;
          in_ready  <= 1'b0;
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end else if (out_ready) begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_ctrl  <= '0;
        end
        FULL: if (out_ready) begin
          state     <= BUSY;
          in_ready  <= 1'b1;
          out_ctrl  <= skid_ctrl;
          out_data  <= skid_data;
          skid_ctrl <= '0;
        end
        default: state <= EMPTY;
      endcase
    end
  end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_elastic_pipe_stage.sv
// tb_elastic_pipe_stage: directed + random stimulus against a FIFO-occupancy model of the stage.
module tb_elastic_pipe_stage;
`ifdef PIPE_PERF_CNT_EN
  localparam int PW = 4;
`else
  localparam int PW = 32;
`endif
  typedef struct packed {
    logic [7:0]   c;
    logic [167:0] d;
  } ent_t;
  logic CLK = 1'b0;
  logic reset = 1'b1, flush = 1'b0, in_valid = 1'b1, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [7:0] in_ctrl = 8'hFF, out_ctrl;
  logic [167:0] in_data = '0, out_data;
  logic [PW-1:0] stall_cnt, bubble_cnt;
  ent_t q[$];
  ent_t e;
  logic ok = 1'b0;
  logic [167:0] last_head = '0;
  logic [PW-1:0] exp_stall = '0, exp_bubble = '0;
  int n_vec = 0, n_err = 0, n;
  elastic_pipe_stage #(.CTRL_W(8), .DATA_W(168), .PERF_W(PW)) dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [167:0] rnd();
    logic [167:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom();
    r[167:160] = 8'($urandom());
    return r;
  endfunction
  // Monitor: the stage is a FIFO of depth 2 with one cycle of latency.
  always @(negedge CLK) begin
    n = q.size();
    if (ok) begin
      chk("out_valid", 168'(out_valid), 168'(n > 0));
      chk("in_ready", 168'(in_ready), 168'(n < 2));
      chk("stall_cnt", 168'(stall_cnt), 168'(exp_stall));
      chk("bubble_cnt", 168'(bubble_cnt), 168'(exp_bubble));
      if (n == 0) begin
        chk("empty_ctrl", 168'(out_ctrl), 168'(0));
        chk("hold_data", out_data, last_head);
      end else begin
        last_head = q[0].d;
        if (out_ready) begin
          e = q.pop_front();
          chk("out_ctrl", 168'(out_ctrl), 168'(e.c));
          chk("out_data", out_data, e.d);
        end
      end
`ifdef PIPE_PERF_CNT_EN
      if (n > 0 && !out_ready && exp_stall != '1) exp_stall++;
      if (n == 0 && exp_bubble != '1) exp_bubble++;
`endif
    end
    if (reset) begin
      q.delete();
      last_head = '0;
      exp_stall = '0;
      exp_bubble = '0;
      ok = 1'b1;
    end else if (flush) q.delete();
  end
  task automatic step(input logic v, input logic [7:0] c, input logic [167:0] d,
                      input logic r, input logic f, input logic rs);
    @(posedge CLK); #1;
    in_valid = v; in_ctrl = c; in_data = d; out_ready = r; flush = f; reset = rs;
    @(negedge CLK); #1;
    if (!reset && !flush && in_valid && in_ready) q.push_back({c, d});
  endtask
  initial begin
    step(1'b1, 8'hFF, rnd(), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hFF, rnd(), 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) step(1'b1, 8'($urandom()), 168'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h11, 168'hA, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h22, 168'hB, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h33, 168'hC, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h81, 168'hD1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h81, 168'hD2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h81, 168'hD3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h5A, rnd(), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, rnd(), 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 22; i++) step(1'b1, 8'h0F, rnd(), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(3) != 0, 8'($urandom()), rnd(), $urandom_range(2) != 0,
           $urandom_range(39) == 0, $urandom_range(499) == 0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
